load_store_unit: RTL



---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_lane_align.sv | 41 ++++
 rtl/load_store_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int unsigned LSU_TIMEOUT = 255;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Misaligned halfword/word, unsigned-size stores and reserved funct3 never reach memory.
  function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = we;
      F3_H:    bad = addr_lo[0];
      F3_HU:   bad = we | addr_lo[0];
      F3_W:    bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables and replicated data, load shift-to-bit-0 and mask.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be_c,
  output logic [31:0] wrep_c,
  output logic [31:0] rshift_c
);

  logic [31:0] shifted;

  assign shifted = rword >> {addr_lo, 3'b000};

  always_comb begin
    be_c     = 4'b0000;
    wrep_c   = wdata;
    rshift_c = 32'h0;
    case (funct3)
      F3_B, F3_BU: begin
        be_c     = 4'b0001 << addr_lo;
        wrep_c   = {4{wdata[7:0]}};
        rshift_c = {24'h0, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        be_c     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wrep_c   = {2{wdata[15:0]}};
        rshift_c = {16'h0, shifted[15:0]};
      end
      F3_W: begin
        be_c     = 4'b1111;
        rshift_c = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequential load/store unit: captures one request, runs the memory req/gnt/rvalid
// handshake with a timeout, and returns lane-aligned load data with an error flag.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = LSU_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        stall_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  lsu_state_e    state_q, state_d;
  lsu_req_t      req_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic [31:0]   rdata_q;

  logic          capture, req_bad, timeout_hit, load_rdata, last_cycle;
  logic          in_req, in_done;
  logic [3:0]    be_c;
  logic [31:0]   wrep_c, rshift_c;

  assign req_bad    = access_err(req_we_i, req_funct3_i, req_addr_i[1:0]);
  assign last_cycle = (cnt_q == CW'(TIMEOUT - 1));
  assign in_req     = (state_q == REQ);
  assign in_done    = (state_q == DONE);

  lsu_lane_align u_align (
    .funct3   (req_q.funct3),
    .addr_lo  (req_q.addr[1:0]),
    .wdata    (req_q.wdata),
    .rword    (mem_rdata_i),
    .be_c     (be_c),
    .wrep_c   (wrep_c),
    .rshift_c (rshift_c)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and handshake strobes; timeout wins over a grant on the last allowed cycle.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    load_rdata  = 1'b0;
    stall_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          stall_o = 1'b1;
          capture = 1'b1;
          state_d = req_bad ? DONE : REQ;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (last_cycle) begin
          timeout_hit = 1'b1;
          state_d     = DONE;
        end else if (mem_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (mem_rvalid_i) begin
          load_rdata = ~req_q.we;
          state_d    = DONE;
        end else if (last_cycle) begin
          timeout_hit = 1'b1;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, timeout counter and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      if (capture) begin
        req_q   <= '{we: req_we_i, funct3: req_funct3_i, addr: req_addr_i, wdata: req_wdata_i};
        err_q   <= req_bad;
        rdata_q <= 32'h0;
        cnt_q   <= '0;
      end else if (state_q == REQ || state_q == WAIT) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (timeout_hit) err_q   <= 1'b1;
      if (load_rdata)  rdata_q <= rshift_c;
    end
  end

  // Memory fields are only driven while requesting, so they read zero elsewhere and in reset.
  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req & req_q.we;
  assign mem_addr_o  = in_req ? {req_q.addr[31:2], 2'b00} : 32'h0;
  assign mem_be_o    = in_req ? be_c : 4'b0000;
  assign mem_wdata_o = in_req ? wrep_c : 32'h0;

  assign rsp_valid_o = in_done;
  assign rsp_err_o   = in_done & err_q;
  assign rsp_rdata_o = in_done ? rdata_q : 32'h0;

endmodule
